// File: rtl/definitions_pkg.sv
// Shared definitions for the token counter and its consumers.
// Holds the token type, the issuer FSM states and the default lane count.
package definitions_pkg;

   localparam int TOKEN_W = 4;

   typedef logic [TOKEN_W-1:0] token_t;

   typedef enum logic [0:0] {
      SYNC = 1'b0,
      RUN  = 1'b1
   } issuer_state_e;

   localparam int ISSUER_NUM_LANES_DEFAULT = 8;

endpackage

// File: rtl/token_slot_issuer_if.sv
// Lane request bus and issued-request output of the token slot issuer.
// The issuer sits on the slave modport; requesters and the sink sit on master.
interface token_slot_issuer_if
   import definitions_pkg::*;
#(
   parameter int NUM_LANES = ISSUER_NUM_LANES_DEFAULT,
   parameter int DATA_W    = 32
);
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   logic [NUM_LANES-1:0]             lane_valid;
   logic [NUM_LANES-1:0][DATA_W-1:0] lane_data;
   logic [NUM_LANES-1:0]             lane_ready;
   logic                             out_valid;
   logic [DATA_W-1:0]                out_data;
   logic [LANE_W-1:0]                out_lane;
   logic                             out_ready;

   modport master (
      output lane_valid, lane_data, out_ready,
      input  lane_ready, out_valid, out_data, out_lane
   );

   modport slave (
      input  lane_valid, lane_data, out_ready,
      output lane_ready, out_valid, out_data, out_lane
   );

endinterface

// File: rtl/token_slot_issuer_lane_hold_buf.sv
// One-entry request holding register for a single lane.
// Clear wins over set; the issuer never clears and sets the same lane in one cycle.
module lane_hold_buf #(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              resetN,
   input  logic              set_en,
   input  logic              clr_en,
   input  logic [DATA_W-1:0] din,
   output logic              held,
   output logic [DATA_W-1:0] dout,
   output logic              ready
);
   logic              held_r;
   logic [DATA_W-1:0] data_r;

   // Hold flag and payload update
   always_ff @(posedge clock) begin
      if (!resetN) begin
         held_r <= 1'b0;
         data_r <= {DATA_W{1'b0}};
      end else if (clr_en) begin
         held_r <= 1'b0;
      end else if (set_en) begin
         held_r <= 1'b1;
         data_r <= din;
      end else begin
         held_r <= held_r;
      end
   end

   assign held  = held_r;
   assign dout  = data_r;
   assign ready = !held_r;

endmodule

// File: rtl/token_slot_issuer.sv
// Issues the buffered request of the lane named by the rotating token onto a
// registered valid/ready output, counting slots lost to output back-pressure.
module token_slot_issuer
   import definitions_pkg::*;
#(
   parameter int NUM_LANES = ISSUER_NUM_LANES_DEFAULT,
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 16
) (
   input  logic                 clock,
   input  logic                 resetN,
   input  logic                 token_set,
   input  token_t               max_token,
   input  token_t               token,
   token_slot_issuer_if.slave   bus,
   output logic                 busy,
   output logic [CNT_W-1:0]     lost_slots
);
   localparam int     LANE_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam bit     ALL_IN_RANGE = (NUM_LANES >= (1 << $bits(token_t)));
   localparam token_t LANES_T      = token_t'(ALL_IN_RANGE ? 0 : NUM_LANES);

   logic [NUM_LANES-1:0] held_s;
   logic [NUM_LANES-1:0] ready_s;
   logic [NUM_LANES-1:0] set_s;
   logic [NUM_LANES-1:0] clr_s;
   logic [DATA_W-1:0]    buf_data_s [NUM_LANES];

   logic [LANE_W-1:0]    tok_idx_s;
   logic                 in_range_s;
   logic                 eligible_s;
   logic                 out_free_s;
   logic                 issue_s;
   logic                 lost_s;

   issuer_state_e        state_r;
   token_t               max_reg_r;
   logic                 out_valid_r;
   logic [DATA_W-1:0]    out_data_r;
   logic [LANE_W-1:0]    out_lane_r;
   logic [CNT_W-1:0]     lost_r;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lane_hold_buf #(.DATA_W(DATA_W)) u_buf (
         .clock  (clock),
         .resetN (resetN),
         .set_en (set_s[g]),
         .clr_en (clr_s[g]),
         .din    (bus.lane_data[g]),
         .held   (held_s[g]),
         .dout   (buf_data_s[g]),
         .ready  (ready_s[g])
      );
   end

   assign set_s          = bus.lane_valid & ready_s;
   assign bus.lane_ready = ready_s;

   // Slot decode; the token is stale during the token_set cycle itself
   always_comb begin
      tok_idx_s  = LANE_W'(token);
      in_range_s = ALL_IN_RANGE || (token < LANES_T);
      eligible_s = 1'b0;
      if ((state_r == RUN) && !token_set && in_range_s && (token <= max_reg_r)) begin
         eligible_s = held_s[tok_idx_s];
      end else begin
         eligible_s = 1'b0;
      end
      out_free_s = !out_valid_r || bus.out_ready;
      issue_s    = eligible_s && out_free_s;
      lost_s     = eligible_s && !out_free_s;
      clr_s      = {NUM_LANES{1'b0}};
      if (issue_s) begin
         clr_s[tok_idx_s] = 1'b1;
      end else begin
         clr_s = {NUM_LANES{1'b0}};
      end
   end

   // Sync FSM and rotation limit
   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_r   <= SYNC;
         max_reg_r <= '0;
      end else if (token_set) begin
         state_r   <= SYNC;
         max_reg_r <= max_token;
      end else begin
         case (state_r)
            SYNC:    state_r <= RUN;
            RUN:     state_r <= RUN;
            default: state_r <= SYNC;
         endcase
      end
   end

   // Output register; only reloads when the previous beat is gone
   always_ff @(posedge clock) begin
      if (!resetN) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_lane_r  <= {LANE_W{1'b0}};
      end else if (issue_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= buf_data_s[tok_idx_s];
         out_lane_r  <= tok_idx_s;
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // Saturating lost-slot counter
   always_ff @(posedge clock) begin
      if (!resetN) begin
         lost_r <= {CNT_W{1'b0}};
      end else if (lost_s && (lost_r != {CNT_W{1'b1}})) begin
         lost_r <= lost_r + CNT_W'(1);
      end else begin
         lost_r <= lost_r;
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_lane  = out_lane_r;
   assign lost_slots    = lost_r;
   assign busy          = (|held_s) || out_valid_r;

endmodule

// File: tb/tb_token_slot_issuer.sv
// Directed bench for token_slot_issuer; the bench plays the token counter.
module tb_token_slot_issuer;
   import definitions_pkg::*;

   localparam int NL = 8;
   localparam int DW = 32;
   localparam int CW = 16;

   logic          clock = 1'b0;
   logic          resetN;
   logic          token_set;
   token_t        max_token;
   token_t        token;
   logic          busy;
   logic [CW-1:0] lost_slots;

   int errors = 0;
   int checks = 0;

   token_slot_issuer_if #(.NUM_LANES(NL), .DATA_W(DW)) bus ();

   token_slot_issuer #(.NUM_LANES(NL), .DATA_W(DW), .CNT_W(CW)) dut (
      .clock      (clock),
      .resetN     (resetN),
      .token_set  (token_set),
      .max_token  (max_token),
      .token      (token),
      .bus        (bus),
      .busy       (busy),
      .lost_slots (lost_slots)
   );

   always #5 clock = ~clock;

   task automatic step(input int t);
      token = token_t'(t);
      @(posedge clock);
      #1;
   endtask

   task automatic drive_lanes(input logic [NL-1:0] v, input logic [DW-1:0] base);
      bus.lane_valid = v;
      for (int i = 0; i < NL; i++) bus.lane_data[i] = base + DW'(i);
   endtask

   task automatic test_reset();
      resetN = 1'b0; token_set = 1'b0; max_token = '0; token = '0;
      bus.lane_valid = '0; bus.lane_data = '0; bus.out_ready = 1'b1;
      step(0); step(0);
      checks++; if (bus.lane_ready !== 8'hFF) begin errors++; $display("FAIL reset_lane_ready: got %h want ff", bus.lane_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_data !== 32'h0 || bus.out_lane !== 3'd0) begin errors++; $display("FAIL reset_out_regs: data %h lane %0d want 0/0", bus.out_data, bus.out_lane); end
      checks++; if (lost_slots !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_lost_busy: lost %0d busy %b want 0/0", lost_slots, busy); end
      resetN = 1'b1;
      step(0);
   endtask

   task automatic test_in_order();
      token_set = 1'b1; max_token = 4'd7;
      drive_lanes(8'hFF, 32'hA0);
      step(0);
      token_set = 1'b0; bus.lane_valid = '0;
      checks++; if (bus.lane_ready !== 8'h00 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL order_capture: ready %h valid %b want 00/0", bus.lane_ready, bus.out_valid); end
      step(0);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL order_sync_idle: valid %b want 0", bus.out_valid); end
      for (int k = 0; k < 8; k++) begin
         step(k);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_lane !== 3'(k) || bus.out_data !== 32'hA0 + 32'(k)) begin
            errors++; $display("FAIL order_slot%0d: valid %b lane %0d data %h want 1/%0d/%h", k, bus.out_valid, bus.out_lane, bus.out_data, k, 32'hA0 + 32'(k));
         end
      end
      step(0);
      checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || lost_slots !== 16'd0) begin errors++; $display("FAIL order_drain: valid %b busy %b lost %0d want 0/0/0", bus.out_valid, busy, lost_slots); end
   endtask

   task automatic test_sparse();
      drive_lanes(8'b0010_0100, 32'h200);
      step(1);
      bus.lane_valid = '0;
      checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b1 || bus.lane_ready !== 8'hDB) begin errors++; $display("FAIL sparse_capture: valid %b busy %b ready %h want 0/1/db", bus.out_valid, busy, bus.lane_ready); end
      for (int t = 2; t < 8; t++) begin
         logic exp_v;
         logic exp_b;
         exp_v = (t == 2) || (t == 5);
         exp_b = (t <= 5);
         step(t);
         checks++;
         if (bus.out_valid !== exp_v || busy !== exp_b) begin
            errors++; $display("FAIL sparse_slot%0d: valid %b busy %b want %b/%b", t, bus.out_valid, busy, exp_v, exp_b);
         end
         if (exp_v) begin
            checks++;
            if (bus.out_lane !== 3'(t) || bus.out_data !== 32'h200 + 32'(t)) begin
               errors++; $display("FAIL sparse_data%0d: lane %0d data %h want %0d/%h", t, bus.out_lane, bus.out_data, t, 32'h200 + 32'(t));
            end
         end
      end
   endtask

   task automatic test_back_pressure();
      drive_lanes(8'b0000_1010, 32'h300);
      step(0);
      bus.lane_valid = '0; bus.out_ready = 1'b0;
      for (int t = 1; t <= 3; t++) begin
         step(t);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_lane !== 3'd1 || bus.out_data !== 32'h301) begin
            errors++; $display("FAIL bp_stable%0d: valid %b lane %0d data %h want 1/1/301", t, bus.out_valid, bus.out_lane, bus.out_data);
         end
      end
      checks++; if (lost_slots !== 16'd1 || bus.lane_ready[3] !== 1'b0) begin errors++; $display("FAIL bp_lost: lost %0d ready3 %b want 1/0", lost_slots, bus.lane_ready[3]); end
      bus.out_ready = 1'b1;
      step(4);
      checks++; if (bus.out_valid !== 1'b0 || bus.lane_ready[3] !== 1'b0) begin errors++; $display("FAIL bp_release: valid %b ready3 %b want 0/0", bus.out_valid, bus.lane_ready[3]); end
      step(5); step(6); step(7); step(0); step(1); step(2);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_wait: valid %b want 0", bus.out_valid); end
      step(3);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_lane !== 3'd3 || bus.out_data !== 32'h303 || lost_slots !== 16'd1) begin errors++; $display("FAIL bp_retry: valid %b lane %0d data %h lost %0d want 1/3/303/1", bus.out_valid, bus.out_lane, bus.out_data, lost_slots); end
      step(4);
   endtask

   task automatic test_reconfig();
      drive_lanes(8'b0100_1111, 32'h400);
      step(5);
      bus.lane_valid = '0;
      checks++; if (bus.lane_ready !== 8'hB0) begin errors++; $display("FAIL cfg_capture: ready %h want b0", bus.lane_ready); end
      token_set = 1'b1; max_token = 4'd3;
      step(6);
      token_set = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL cfg_set_cycle: valid %b want 0", bus.out_valid); end
      step(6);
      checks++; if (bus.out_valid !== 1'b0 || bus.lane_ready[6] !== 1'b0) begin errors++; $display("FAIL cfg_sync: valid %b ready6 %b want 0/0", bus.out_valid, bus.lane_ready[6]); end
      for (int k = 0; k < 4; k++) begin
         step(k);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_lane !== 3'(k) || bus.out_data !== 32'h400 + 32'(k)) begin
            errors++; $display("FAIL cfg_slot%0d: valid %b lane %0d data %h want 1/%0d/%h", k, bus.out_valid, bus.out_lane, bus.out_data, k, 32'h400 + 32'(k));
         end
      end
      for (int k = 0; k < 4; k++) begin
         step(k);
         checks++;
         if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL cfg_idle%0d: valid %b want 0", k, bus.out_valid); end
      end
      checks++; if (bus.lane_ready !== 8'hBF || busy !== 1'b1) begin errors++; $display("FAIL cfg_lane6_held: ready %h busy %b want bf/1", bus.lane_ready, busy); end
   endtask

   task automatic test_out_of_range();
      token_set = 1'b1; max_token = 4'd11;
      drive_lanes(8'h01, 32'h500);
      step(3);
      token_set = 1'b0; bus.lane_valid = '0;
      step(0);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL oor_sync: valid %b want 0", bus.out_valid); end
      for (int t = 0; t < 7; t++) begin
         logic exp_v;
         exp_v = (t == 0) || (t == 6);
         step(t);
         checks++;
         if (bus.out_valid !== exp_v) begin errors++; $display("FAIL oor_slot%0d: valid %b want %b", t, bus.out_valid, exp_v); end
      end
      checks++; if (bus.out_lane !== 3'd6 || bus.out_data !== 32'h406) begin errors++; $display("FAIL oor_lane6: lane %0d data %h want 6/406", bus.out_lane, bus.out_data); end
      bus.out_ready = 1'b0;
      bus.lane_data[0] = 32'h600;
      for (int t = 7; t < 12; t++) begin
         bus.lane_valid = (t == 8) ? 8'h01 : 8'h00;
         step(t);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_lane !== 3'd6 || lost_slots !== 16'd1) begin
            errors++; $display("FAIL oor_idle%0d: valid %b lane %0d lost %0d want 1/6/1", t, bus.out_valid, bus.out_lane, lost_slots);
         end
      end
      bus.lane_valid = '0; bus.out_ready = 1'b1;
      step(0);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_lane !== 3'd0 || bus.out_data !== 32'h600 || lost_slots !== 16'd1) begin errors++; $display("FAIL oor_wrap: valid %b lane %0d data %h lost %0d want 1/0/600/1", bus.out_valid, bus.out_lane, bus.out_data, lost_slots); end
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      drive_lanes(8'b0001_1110, 32'h700);
      step(1);
      bus.lane_valid = '0;
      checks++; if (bus.lane_ready !== 8'hE1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre: ready %h valid %b want e1/1", bus.lane_ready, bus.out_valid); end
      resetN = 1'b0;
      step(2);
      checks++; if (bus.lane_ready !== 8'hFF || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out: ready %h valid %b want ff/0", bus.lane_ready, bus.out_valid); end
      checks++; if (lost_slots !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_cnt: lost %0d busy %b want 0/0", lost_slots, busy); end
      resetN = 1'b1; bus.out_ready = 1'b1;
      step(0);
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_sparse();
      test_back_pressure();
      test_reconfig();
      test_out_of_range();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
